// File: rtl/alu_32_bit_scheduler.sv
// Arbitrates two requesters onto one shared ALU_32_bit, then issues the operation,
// holds it for WAIT_CYCLES, captures the result, and presents it until the response is taken.
module alu_32_bit_scheduler #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_operand1,
    input  logic [31:0] req0_operand2,
    input  logic [31:0] req1_operand1,
    input  logic [31:0] req1_operand2,
    input  logic [3:0]  req0_opcode,
    input  logic [3:0]  req1_opcode,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    output logic [3:0]  alu_opcode,
    input  logic [63:0] alu_result,
    input  logic        alu_flagC,
    input  logic        alu_flagZ,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [63:0] resp_result,
    output logic        resp_flagC,
    output logic        resp_flagZ,
    input  logic        resp_ready,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Out-of-range parameter values are clamped so the counter can never stall at zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES < 1)  ? 4'd1  :
                                       (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  cnt_r;
    logic        id_r;
    logic        last_grant_r;
    logic        busy_r;
    logic        grant_s;
    logic        idle_s;
    logic        req0_ready_s;
    logic        req1_ready_s;
    logic        xfer_s;
    logic        capture_s;
    logic        hshk_s;
    logic [31:0] alu_operand1_r;
    logic [31:0] alu_operand2_r;
    logic [3:0]  alu_opcode_r;
    logic        resp_valid_r;
    logic        resp_id_r;
    logic [63:0] resp_result_r;
    logic        resp_flagC_r;
    logic        resp_flagZ_r;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is gated by reset so it drops immediately while reset is asserted.
    always_comb begin
        idle_s       = (state_r == IDLE) && !reset;
        req0_ready_s = idle_s && req0_valid && !grant_s;
        req1_ready_s = idle_s && req1_valid && grant_s;
        xfer_s       = req0_ready_s || req1_ready_s;
        capture_s    = (state_r == EXEC) && (cnt_r == 4'd1);
        hshk_s       = (state_r == RESP) && resp_valid_r && resp_ready;
    end

    // Next-state selection for the issue / execute / respond sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (capture_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                if (hshk_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and busy flag; busy is registered from the next state so it tracks state_r exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Execution hold counter; stops at 1 once the capture edge has been reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (xfer_s) begin
            cnt_r <= WAIT_LOAD;
        end else if ((state_r == EXEC) && (cnt_r > 4'd1)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // ALU operand registers; they keep the last issued operation outside of a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_operand1_r <= 32'd0;
            alu_operand2_r <= 32'd0;
            alu_opcode_r   <= 4'd0;
            id_r           <= 1'b0;
        end else if (xfer_s) begin
            alu_operand1_r <= grant_s ? req1_operand1 : req0_operand1;
            alu_operand2_r <= grant_s ? req1_operand2 : req0_operand2;
            alu_opcode_r   <= grant_s ? req1_opcode   : req0_opcode;
            id_r           <= grant_s;
        end else begin
            alu_operand1_r <= alu_operand1_r;
            alu_operand2_r <= alu_operand2_r;
            alu_opcode_r   <= alu_opcode_r;
            id_r           <= id_r;
        end
    end

    // Response registers: load on the capture edge, hold until the consumer takes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_r  <= 1'b0;
            resp_id_r     <= 1'b0;
            resp_result_r <= 64'd0;
            resp_flagC_r  <= 1'b0;
            resp_flagZ_r  <= 1'b0;
        end else if (capture_s) begin
            resp_valid_r  <= 1'b1;
            resp_id_r     <= id_r;
            resp_result_r <= alu_result;
            resp_flagC_r  <= alu_flagC;
            resp_flagZ_r  <= alu_flagZ;
        end else if (hshk_s) begin
            resp_valid_r  <= 1'b0;
            resp_id_r     <= resp_id_r;
            resp_result_r <= resp_result_r;
            resp_flagC_r  <= resp_flagC_r;
            resp_flagZ_r  <= resp_flagZ_r;
        end else begin
            resp_valid_r  <= resp_valid_r;
            resp_id_r     <= resp_id_r;
            resp_result_r <= resp_result_r;
            resp_flagC_r  <= resp_flagC_r;
            resp_flagZ_r  <= resp_flagZ_r;
        end
    end

    // Round-robin pointer advances only when a response is handed off; reset favours req0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (hshk_s) begin
            last_grant_r <= resp_id_r;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign req0_ready   = req0_ready_s;
    assign req1_ready   = req1_ready_s;
    assign alu_operand1 = alu_operand1_r;
    assign alu_operand2 = alu_operand2_r;
    assign alu_opcode   = alu_opcode_r;
    assign resp_valid   = resp_valid_r;
    assign resp_id      = resp_id_r;
    assign resp_result  = resp_result_r;
    assign resp_flagC   = resp_flagC_r;
    assign resp_flagZ   = resp_flagZ_r;
    assign busy         = busy_r;

endmodule

// File: doc/alu_32_bit_scheduler.md
ALU_32_BIT_SCHEDULER -- requirements
Module: alu_32_bit_scheduler
Shares one ALU_32_bit between two requesters; sequences issue, capture and response.

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning cycles operands are held on the ALU before result capture (legal 1..15).
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  scheduler accepts requester N's operation this cycle.
REQ-006 req0_operand1, req0_operand2, req1_operand1, req1_operand2  input  32  operands.
REQ-007 req0_opcode / req1_opcode  input  4  ALU opcode; all 16 values forwarded unchanged.
REQ-008 alu_operand1, alu_operand2  output  32 each; alu_opcode  output  4  drive ALU_32_bit.
REQ-009 alu_result  input  64; alu_flagC, alu_flagZ  input  1  from ALU_32_bit.
REQ-010 resp_valid  output  1; resp_id  output  1 (requester served); resp_result  output  64; resp_flagC, resp_flagZ  output  1.
REQ-011 resp_ready  input  1  consumer accepts response.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-014 IDLE: grant = only valid requester if one valid; if both valid, the one not served last (round-robin pointer last_grant).
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; combinational from valids and last_grant; at most one ready high.
REQ-016 Transfer occurs on the edge where reqN_valid and reqN_ready are both high; operands, opcode and id registered onto alu_* and an internal id register; FSM -> EXEC; 4-bit counter loaded with WAIT_CYCLES.
REQ-017 EXEC: each edge with counter==1 captures alu_result, alu_flagC, alu_flagZ into resp_* and goes to RESP; otherwise counter decrements.
REQ-018 Latency: resp_valid rises exactly WAIT_CYCLES edges after the transfer edge.
REQ-019 RESP: resp_valid high; resp_id, resp_result, resp_flagC, resp_flagZ stable until handshake.
REQ-020 Edge with resp_valid and resp_ready high: FSM -> IDLE, resp_valid low, last_grant <= resp_id; no new request accepted in that same cycle.
REQ-021 resp_ready while resp_valid low SHALL be ignored.
REQ-022 Requester dropping valid before ready SHALL cause no transfer and no state change.
REQ-023 alu_* outputs SHALL hold last issued values in IDLE and RESP (no glitching to zero).
REQ-024 Throughput: one operation per WAIT_CYCLES+2 cycles with resp_ready held high.

Reset
REQ-025 reset high SHALL immediately force state IDLE, counter 0, all outputs 0 (ready, resp_*, alu_*, busy), last_grant = 1 so req0 wins the first tie.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-027 First transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
(ALU stub: alu_result = {alu_operand1, alu_operand2}; alu_flagZ = (alu_opcode==4'hF); alu_flagC = (alu_opcode==4'h3).)
REQ-028 req0 ABCDABCD/83635273, opcode 4'h3, resp_ready=1 -> resp_valid 1 edge after transfer, resp_id=0, resp_result=64'hABCDABCD_83635273, resp_flagC=1, resp_flagZ=0.
REQ-029 req0 and req1 both valid continuously after reset, req1 operands 00000001/00000002 -> service order 0,1,0,1; resp_result alternates accordingly.
REQ-030 resp_ready low 5 cycles in RESP -> resp_valid and all resp_* stable, req0_ready=req1_ready=0, busy=1 throughout.
REQ-031 reset pulsed during EXEC (WAIT_CYCLES=3) -> all outputs 0 same cycle, no response emitted, next tie granted to req0.
REQ-032 WAIT_CYCLES=3, req1 opcode 4'hF -> resp_valid 3 edges after transfer, resp_flagZ=1, resp_id=1.
REQ-033 all 16 opcodes from req1 sequentially -> alu_opcode matches each during EXEC; 16 responses, none lost or duplicated.
